// File: rtl/odd_seq_pkg.sv
// Shared definitions for the odd-sequence checker: FSM states and the default
// step/lock constants also used by the odd counter bench.
package odd_seq_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } seq_state_e;

    localparam int unsigned DEF_STEP     = 2;
    localparam int unsigned DEF_LOCK_CNT = 3;

endpackage

// File: rtl/odd_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle
// increment, and the count sticks at all-ones.
module odd_seq_sat_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/odd_seq_checker.sv
// Monitors an odd-counter bus: acquires the 1,3,5,... sequence, then flags
// every deviation with a pulse and a saturating error tally.
module odd_seq_checker
    import odd_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP     = DEF_STEP,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             in_valid,
    input  logic             clear_err,
    output logic             locked,
    output logic             mismatch,
    output logic             wrap_seen,
    output logic [WIDTH-1:0] expected,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned      RUN_W  = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
    localparam logic [RUN_W:0]   LOCK_V = (RUN_W + 1)'(LOCK_CNT);

    seq_state_e       state_q;
    logic             locked_q;
    logic             mismatch_q;
    logic             wrap_q;
    logic [WIDTH-1:0] expected_q;
    logic [RUN_W-1:0] run_q;

    logic             hit;
    logic             err_inc;
    logic [WIDTH-1:0] next_exp;
    logic [RUN_W:0]   run_inc;

    // NOTE: every always_comb output gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        hit      = (count_in == expected_q);
        next_exp = count_in + STEP_V;
        run_inc  = {1'b0, run_q} + (RUN_W + 1)'(1);
        err_inc  = in_valid && (state_q == LOCKED) && !hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SEARCH;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
            expected_q <= ONE_V;
            run_q      <= '0;
        end else begin
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
            if (in_valid) begin
                if ((state_q != SEARCH) && hit) begin
                    expected_q <= next_exp;
                    if (state_q == LOCKED) begin
                        wrap_q <= (count_in == ONE_V);
                    end else if (run_inc >= LOCK_V) begin
                        // Run saturates at LOCK_CNT, which also covers LOCK_CNT=1.
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        run_q    <= LOCK_V[RUN_W-1:0];
                    end else begin
                        run_q <= run_inc[RUN_W-1:0];
                    end
                end else begin
                    if (state_q == LOCKED) begin
                        mismatch_q <= 1'b1;
                        locked_q   <= 1'b0;
                    end
                    // Resync: an odd sample seeds a new prediction, an even one
                    // leaves the old prediction in place and restarts the search.
                    if (count_in[0]) begin
                        expected_q <= next_exp;
                        run_q      <= RUN_W'(1);
                        state_q    <= ACQUIRE;
                    end else begin
                        run_q   <= '0;
                        state_q <= SEARCH;
                    end
                end
            end
        end
    end

    odd_seq_sat_cnt #(
        .WIDTH(ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (err_inc),
        .clear_i (clear_err),
        .count_o (err_count)
    );

    assign locked    = locked_q;
    assign mismatch  = mismatch_q;
    assign wrap_seen = wrap_q;
    assign expected  = expected_q;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Scenario bench for odd_seq_checker: expected outputs are queued as each
// sample is driven and compared one edge later.
module tb_odd_seq_checker;

    typedef struct packed {
        logic       locked;
        logic       mismatch;
        logic       wrap;
        logic [7:0] expected;
        logic [1:0] err;
    } obs_t;

    typedef struct packed {
        logic       valid;
        logic       clear;
        logic [7:0] count;
        obs_t       exp;
    } row_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] count_in = 8'd0;
    logic       in_valid = 1'b0;
    logic       clear_err = 1'b0;

    logic       locked, mismatch, wrap_seen;
    logic [7:0] expected;
    logic [1:0] err_count;

    logic       locked1, mismatch1, wrap_seen1;
    logic [7:0] expected1;
    logic [7:0] err_count1;

    obs_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    odd_seq_checker #(
        .WIDTH(8), .STEP(2), .LOCK_CNT(3), .ERR_W(2)
    ) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .in_valid(in_valid),
        .clear_err(clear_err), .locked(locked), .mismatch(mismatch),
        .wrap_seen(wrap_seen), .expected(expected), .err_count(err_count)
    );

    odd_seq_checker #(
        .WIDTH(8), .STEP(2), .LOCK_CNT(1), .ERR_W(8)
    ) dut1 (
        .clk(clk), .rst(rst), .count_in(count_in), .in_valid(in_valid),
        .clear_err(clear_err), .locked(locked1), .mismatch(mismatch1),
        .wrap_seen(wrap_seen1), .expected(expected1), .err_count(err_count1)
    );

    function automatic obs_t sample();
        obs_t o;
        o.locked   = locked;
        o.mismatch = mismatch;
        o.wrap     = wrap_seen;
        o.expected = expected;
        o.err      = err_count;
        return o;
    endfunction

    function automatic obs_t sample1();
        obs_t o;
        o.locked   = locked1;
        o.mismatch = mismatch1;
        o.wrap     = wrap_seen1;
        o.expected = expected1;
        o.err      = (err_count1 > 8'd3) ? 2'd3 : err_count1[1:0];
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("L=%b M=%b W=%b E=%0d C=%0d",
                         o.locked, o.mismatch, o.wrap, o.expected, o.err);
    endfunction

    function automatic row_t mk(input logic v, input logic [7:0] c, input logic clr,
                                input logic l, input logic m, input logic w,
                                input logic [7:0] e, input logic [1:0] n);
        row_t r;
        r.valid        = v;
        r.count        = c;
        r.clear        = clr;
        r.exp.locked   = l;
        r.exp.mismatch = m;
        r.exp.wrap     = w;
        r.exp.expected = e;
        r.exp.err      = n;
        return r;
    endfunction

    task automatic apply(input row_t r);
        @(negedge clk);
        in_valid  = r.valid;
        count_in  = r.count;
        clear_err = r.clear;
        sb.push_back(r.exp);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        clear_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, want;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        sb.push_back(obs_t'{1'b0, 1'b0, 1'b0, 8'd1, 2'd0});
        #1;
        got = sample(); want = sb.pop_front(); n_total++;
        if (got !== want) $display("FAIL reset: got %s, want %s", fmt(got), fmt(want));
        else n_pass++;
        sb.push_back(obs_t'{1'b0, 1'b0, 1'b0, 8'd1, 2'd0});
        got = sample1(); want = sb.pop_front(); n_total++;
        if (got !== want) $display("FAIL reset_l1: got %s, want %s", fmt(got), fmt(want));
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lock();
        row_t rows[$];
        obs_t got, want;
        reset_dut();
        rows.push_back(mk(1, 8'd1, 0, 0, 0, 0, 8'd3, 0));
        rows.push_back(mk(1, 8'd3, 0, 0, 0, 0, 8'd5, 0));
        rows.push_back(mk(1, 8'd5, 0, 1, 0, 0, 8'd7, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); n_total++;
            if (got !== want) $display("FAIL lock[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        row_t rows[$];
        obs_t got, want;
        reset_dut();
        rows.push_back(mk(1, 8'd245, 0, 0, 0, 0, 8'd247, 0));
        rows.push_back(mk(1, 8'd247, 0, 0, 0, 0, 8'd249, 0));
        rows.push_back(mk(1, 8'd249, 0, 1, 0, 0, 8'd251, 0));
        rows.push_back(mk(1, 8'd251, 0, 1, 0, 0, 8'd253, 0));
        rows.push_back(mk(1, 8'd253, 0, 1, 0, 0, 8'd255, 0));
        rows.push_back(mk(1, 8'd255, 0, 1, 0, 0, 8'd1,   0));
        rows.push_back(mk(1, 8'd1,   0, 1, 0, 1, 8'd3,   0));
        rows.push_back(mk(1, 8'd3,   0, 1, 0, 0, 8'd5,   0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); n_total++;
            if (got !== want) $display("FAIL wrap[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else n_pass++;
        end
    endtask

    task automatic test_mismatch();
        row_t rows[$];
        obs_t got, want;
        reset_dut();
        rows.push_back(mk(1, 8'd1,  0, 0, 0, 0, 8'd3,  0));
        rows.push_back(mk(1, 8'd3,  0, 0, 0, 0, 8'd5,  0));
        rows.push_back(mk(1, 8'd5,  0, 1, 0, 0, 8'd7,  0));
        rows.push_back(mk(1, 8'd7,  0, 1, 0, 0, 8'd9,  0));
        rows.push_back(mk(1, 8'd12, 0, 0, 1, 0, 8'd9,  1));
        rows.push_back(mk(1, 8'd13, 0, 0, 0, 0, 8'd15, 1));
        rows.push_back(mk(1, 8'd15, 0, 0, 0, 0, 8'd17, 1));
        rows.push_back(mk(1, 8'd17, 0, 1, 0, 0, 8'd19, 1));
        rows.push_back(mk(1, 8'd19, 0, 1, 0, 0, 8'd21, 1));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); n_total++;
            if (got !== want) $display("FAIL mismatch[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        row_t rows[$];
        obs_t got, want;
        logic [1:0] c;
        reset_dut();
        rows.push_back(mk(1, 8'd1, 0, 0, 0, 0, 8'd3, 0));
        rows.push_back(mk(1, 8'd3, 0, 0, 0, 0, 8'd5, 0));
        rows.push_back(mk(1, 8'd5, 0, 1, 0, 0, 8'd7, 0));
        for (int k = 1; k <= 5; k++) begin
            c = (k == 5) ? 2'd0 : ((k > 3) ? 2'd3 : 2'(k));
            rows.push_back(mk(1, 8'd255, (k == 5), 0, 1, 0, 8'd1, c));
            rows.push_back(mk(1, 8'd1,   0,        0, 0, 0, 8'd3, c));
            rows.push_back(mk(1, 8'd3,   0,        1, 0, 0, 8'd5, c));
        end
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); n_total++;
            if (got !== want) $display("FAIL saturate[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        row_t rows[$];
        obs_t got, want;
        reset_dut();
        rows.push_back(mk(1, 8'd251, 0, 0, 0, 0, 8'd253, 0));
        rows.push_back(mk(1, 8'd253, 0, 0, 0, 0, 8'd255, 0));
        rows.push_back(mk(1, 8'd255, 0, 1, 0, 0, 8'd1,   0));
        rows.push_back(mk(1, 8'd1,   0, 1, 0, 1, 8'd3,   0));
        for (int k = 0; k < 4; k++)
            rows.push_back(mk(0, 8'($urandom_range(0, 255)), 0, 1, 0, 0, 8'd3, 0));
        rows.push_back(mk(1, 8'd3, 0, 1, 0, 0, 8'd5, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); n_total++;
            if (got !== want) $display("FAIL hold[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        row_t post[$];
        obs_t got, want;
        reset_dut();
        rows.push_back(mk(1, 8'd1,  0, 0, 0, 0, 8'd3,  0));
        rows.push_back(mk(1, 8'd3,  0, 0, 0, 0, 8'd5,  0));
        rows.push_back(mk(1, 8'd5,  0, 1, 0, 0, 8'd7,  0));
        rows.push_back(mk(1, 8'd12, 0, 0, 1, 0, 8'd7,  1));
        rows.push_back(mk(1, 8'd13, 0, 0, 0, 0, 8'd15, 1));
        rows.push_back(mk(1, 8'd15, 0, 0, 0, 0, 8'd17, 1));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); n_total++;
            if (got !== want) $display("FAIL reset_mid_pre[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else n_pass++;
        end
        #2;
        rst = 1'b1;
        sb.push_back(obs_t'{1'b0, 1'b0, 1'b0, 8'd1, 2'd0});
        #1;
        got = sample(); want = sb.pop_front(); n_total++;
        if (got !== want) $display("FAIL reset_mid_async: got %s, want %s", fmt(got), fmt(want));
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        post.push_back(mk(1, 8'd3, 0, 0, 0, 0, 8'd5, 0));
        post.push_back(mk(1, 8'd5, 0, 0, 0, 0, 8'd7, 0));
        post.push_back(mk(1, 8'd7, 0, 1, 0, 0, 8'd9, 0));
        foreach (post[i]) begin
            apply(post[i]);
            @(posedge clk); #1;
            got = sample(); want = sb.pop_front(); n_total++;
            if (got !== want) $display("FAIL reset_mid_post[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else n_pass++;
        end
    endtask

    task automatic test_lock_one();
        row_t rows[$];
        obs_t got, want;
        reset_dut();
        rows.push_back(mk(1, 8'd7,  0, 0, 0, 0, 8'd9,  0));
        rows.push_back(mk(1, 8'd9,  0, 1, 0, 0, 8'd11, 0));
        rows.push_back(mk(1, 8'd11, 0, 1, 0, 0, 8'd13, 0));
        rows.push_back(mk(1, 8'd20, 0, 0, 1, 0, 8'd13, 1));
        rows.push_back(mk(1, 8'd21, 0, 0, 0, 0, 8'd23, 1));
        rows.push_back(mk(1, 8'd23, 0, 1, 0, 0, 8'd25, 1));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            got = sample1(); want = sb.pop_front(); n_total++;
            if (got !== want) $display("FAIL lock_one[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_mismatch();
        test_saturate();
        test_hold();
        test_reset_mid();
        test_lock_one();
        @(negedge clk);
        in_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
